gpio_ir_arb: RTL and testbench
==============================

GPIO_IR_ARB -- requirements
Module: gpio_ir_arb

Interface
REQ-001 Parameter PORT_NUM, default 8, number of GPIO pins; there are PORT_NUM+1 interrupt sources, index PORT_NUM being the all-pins interrupt.
REQ-002 Parameter ID_WIDTH, default 4, width of the granted-source index; SHALL satisfy 2^ID_WIDTH >= PORT_NUM+1.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ir_valid  input  PORT_NUM+1  per-source interrupt request, one valid/ready channel per source.
REQ-006 ir_ready  output  PORT_NUM+1  per-source accept.
REQ-007 flush  input  1  discard all pending interrupts that are not yet granted.
REQ-008 out_valid  output  1  one granted interrupt is presented.
REQ-009 out_ready  input  1  downstream (single sync_to_async channel) accepts the grant.
REQ-010 out_id  output  ID_WIDTH  index of the granted source.
REQ-011 pend_cnt  output  ID_WIDTH+1  number of set pending bits, granted bit included.

Function
REQ-012 Per-source pending bit; ir_ready[i] = ~pending[i] & ~flush (combinational from registered state and flush).
REQ-013 ir_valid[i] & ir_ready[i] at an edge SHALL set pending[i]; that transfer counts as one accepted interrupt.
REQ-014 FSM states IDLE and GRANT; reset state IDLE.
REQ-015 IDLE: if any pending bit is set, select one round-robin, register its index into out_id and go to GRANT at the same edge; otherwise stay in IDLE.
REQ-016 Round-robin search starts at last_grant+1 and proceeds upward, wrapping from PORT_NUM to 0; last_grant resets to PORT_NUM, so the first search starts at source 0.
REQ-017 GRANT: out_valid=1; out_id SHALL be held stable until out_valid&out_ready.
REQ-018 GRANT with out_ready=1: clear pending[out_id], set last_grant=out_id, go to IDLE; out_valid=0 the next cycle.
REQ-019 Latency: a source accepted at edge k into an idle arbiter with no other pending source SHALL give out_valid=1 from cycle k+2; the minimum spacing between grants is 2 cycles.
REQ-020 While granted, a source's pending bit stays set, so its ir_ready stays 0 and no second request from that source is accepted until its grant completes.
REQ-021 Request and completion in the same cycle: because ir_ready is registered-state based, the re-request is accepted at the earliest edge after the clear.
REQ-022 flush=1 at an edge SHALL clear every pending bit except the currently granted one while in GRANT; the GRANT handshake completes normally and out_valid is never dropped early.
REQ-023 flush in IDLE SHALL clear all pending bits and suppress selection at that edge, so the state stays IDLE.
REQ-024 flush forces ir_ready to 0, so no request is accepted and lost in the flush cycle.
REQ-025 pend_cnt SHALL be the registered popcount of the pending bits, updated on the edge after each change; it never exceeds PORT_NUM+1.
REQ-026 ir_valid on a source with its pending bit set SHALL cause no state change; upstream holds the request.

Reset
REQ-027 While reset is high at an edge: pending=0, state=IDLE, last_grant=PORT_NUM, out_id=0, pend_cnt=0.
REQ-028 Outputs during and after reset, until new requests arrive: out_valid=0, ir_ready all 1.
REQ-029 Reset mid-GRANT SHALL abandon the grant; out_valid falls the cycle after the reset edge.
REQ-030 reset has priority over flush and over all handshakes.

Verification
REQ-031 After reset, pulse ir_valid[3] for one cycle, out_ready=1 -> out_valid high 2 cycles after acceptance with out_id=3; pend_cnt goes 1 then 0; ir_ready[3] goes low and then high again.
REQ-032 Sources 0, 2 and 8 request in the same cycle, out_ready=1 -> grant order 0, 2, 8; then sources 0 and 8 request again -> order 0, 8 (continuing from last_grant=8, the search wraps to 0 first).
REQ-033 Grant to source 5 with out_ready=0 for 10 cycles -> out_valid and out_id=5 stable throughout; ir_ready[5]=0; requests from other sources are still accepted; pend_cnt rises accordingly.
REQ-034 Pending {1,4,6} with 1 granted and out_ready=0; assert flush for one cycle -> pending becomes {1}, pend_cnt=1; on out_ready=1, grant 1 completes and no further out_valid follows.
REQ-035 Assert reset while in GRANT with 3 sources pending -> next cycle out_valid=0, pend_cnt=0, ir_ready all 1; a new request on source 7 is then granted first, with out_id=7.
REQ-036 All 9 sources request in the same cycle, out_ready=1 constant -> 9 grants in order 0..8, spaced 2 cycles apart, with no request lost or duplicated.

Source files
------------

// File: rtl/gpio_ir_arb.sv
// GPIO interrupt arbiter: one pending bit per source (PORT_NUM pins plus the
// all-pins interrupt), round-robin selection of a single grant presented on
// one valid/ready output channel.
module gpio_ir_arb #(
  parameter int PORT_NUM = 8,
  parameter int ID_WIDTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PORT_NUM:0]   ir_valid,
  output logic [PORT_NUM:0]   ir_ready,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ID_WIDTH-1:0] out_id,
  output logic [ID_WIDTH:0]   pend_cnt
);

  localparam int unsigned NSRC = PORT_NUM + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state, state_nxt;
  logic [PORT_NUM:0]   pending, pending_nxt;
  logic [PORT_NUM:0]   grant_mask;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] sel_id;
  logic                sel_valid;
  logic [ID_WIDTH:0]   pop;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: select only from registered pending bits and never on a flush edge
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (sel_valid && !flush) state_nxt = GRANT;
      GRANT: if (out_ready)           state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state and registered pending bits
  always_comb begin
    out_valid = (state == GRANT);
    ir_ready  = ~pending & {NSRC{~flush}};
  end

  // Round-robin pick: first set bit above last_grant, else lowest set bit (wrap)
  always_comb begin
    logic                hi_found;
    logic [ID_WIDTH-1:0] hi_id;
    logic [ID_WIDTH-1:0] lo_id;
    hi_found  = 1'b0;
    hi_id     = '0;
    lo_id     = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (pending[i] && !sel_valid) begin
        sel_valid = 1'b1;
        lo_id     = ID_WIDTH'(i);
      end
      if (pending[i] && !hi_found && (i > 32'(last_grant))) begin
        hi_found = 1'b1;
        hi_id    = ID_WIDTH'(i);
      end
    end
    sel_id = hi_found ? hi_id : lo_id;
  end

  // One-hot mask of the currently granted source and popcount of pending bits
  always_comb begin
    grant_mask = '0;
    pop        = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      grant_mask[i] = (32'(out_id) == i);
      pop           = pop + (ID_WIDTH + 1)'(pending[i]);
    end
  end

  // Pending update: flush keeps only an active grant, then accepts, then completion
  always_comb begin
    pending_nxt = pending;
    if (flush) begin
      if (state == GRANT) pending_nxt = pending & grant_mask;
      else                pending_nxt = '0;
    end
    pending_nxt = pending_nxt | (ir_valid & ir_ready);
    if (state == GRANT && out_ready) pending_nxt = pending_nxt & ~grant_mask;
  end

  // Datapath registers: pending bits, grant index, round-robin pointer, count
  always_ff @(posedge clock) begin
    if (reset) begin
      pending    <= '0;
      out_id     <= '0;
      last_grant <= ID_WIDTH'(PORT_NUM);
      pend_cnt   <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= pop;
      if (state == IDLE && sel_valid && !flush) out_id <= sel_id;
      if (state == GRANT && out_ready)          last_grant <= out_id;
    end
  end

endmodule

// File: tb/tb_gpio_ir_arb.sv
// Directed bench for gpio_ir_arb: a vector table for the basic request,
// round-robin and idle-flush behaviour, then hand sequences for stall,
// flush-in-grant, reset-in-grant, re-request and all-sources cases.
module tb_gpio_ir_arb;

  localparam int PORT_NUM = 8;
  localparam int ID_WIDTH = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [PORT_NUM:0]   ir_valid = '0;
  logic [PORT_NUM:0]   ir_ready;
  logic                flush = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [ID_WIDTH-1:0] out_id;
  logic [ID_WIDTH:0]   pend_cnt;

  int checks = 0;
  int errors = 0;

  gpio_ir_arb #(.PORT_NUM(PORT_NUM), .ID_WIDTH(ID_WIDTH)) dut (
    .clock(clock), .reset(reset), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_id(out_id), .pend_cnt(pend_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       fl;
    logic       ordy;
    logic [8:0] valid;
    logic       ov;
    logic [3:0] id;
    logic [4:0] cnt;
    logic [8:0] rdy;
  } vec_t;

  vec_t vec [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; ir_valid = '0; out_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Each row: inputs applied, outputs observed before the edge consuming them
    //           rst   fl    ordy  valid    ov    id     cnt    rdy
    vec[0]  = '{1'b0, 1'b0, 1'b1, 9'h008, 1'b0, 4'd0, 5'd0, 9'h1FF};
    vec[1]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 5'd0, 9'h1F7};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 4'd3, 5'd1, 9'h1F7};
    vec[3]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd3, 5'd1, 9'h1FF};
    vec[4]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd3, 5'd0, 9'h1FF};
    vec[5]  = '{1'b1, 1'b0, 1'b1, 9'h000, 1'b0, 4'd3, 5'd0, 9'h1FF};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 9'h105, 1'b0, 4'd0, 5'd0, 9'h1FF};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 5'd0, 9'h0FA};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 4'd0, 5'd3, 9'h0FA};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 5'd3, 9'h0FB};
    vec[10] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 4'd2, 5'd2, 9'h0FB};
    vec[11] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd2, 5'd2, 9'h0FF};
    vec[12] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 4'd8, 5'd1, 9'h0FF};
    vec[13] = '{1'b0, 1'b0, 1'b1, 9'h101, 1'b0, 4'd8, 5'd1, 9'h1FF};
    vec[14] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd8, 5'd0, 9'h0FE};
    vec[15] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 4'd0, 5'd2, 9'h0FE};
    vec[16] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd0, 5'd2, 9'h0FF};
    vec[17] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b1, 4'd8, 5'd1, 9'h0FF};
    vec[18] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd8, 5'd1, 9'h1FF};
    vec[19] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd8, 5'd0, 9'h1FF};
    vec[20] = '{1'b0, 1'b0, 1'b1, 9'h010, 1'b0, 4'd8, 5'd0, 9'h1FF};
    vec[21] = '{1'b0, 1'b1, 1'b1, 9'h020, 1'b0, 4'd8, 5'd0, 9'h000};
    vec[22] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd8, 5'd1, 9'h1FF};
    vec[23] = '{1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 4'd8, 5'd0, 9'h1FF};

    tick();
    do_reset();

    for (int i = 0; i < 24; i++) begin
      reset     = vec[i].rst;
      flush     = vec[i].fl;
      out_ready = vec[i].ordy;
      ir_valid  = vec[i].valid;
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vec[i].ov));
      check($sformatf("v%0d_out_id", i),    32'(out_id),    32'(vec[i].id));
      check($sformatf("v%0d_pend_cnt", i),  32'(pend_cnt),  32'(vec[i].cnt));
      check($sformatf("v%0d_ir_ready", i),  32'(ir_ready),  32'(vec[i].rdy));
      tick();
    end
    reset = 1'b0; flush = 1'b0; ir_valid = '0;

    // Stalled grant to source 5; other sources still accepted
    do_reset();
    ir_valid = 9'h020;
    tick();
    ir_valid = '0;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("stall_ov", 32'(out_valid), 32'd1);
      check("stall_id", 32'(out_id), 32'd5);
      check("stall_rdy5", 32'(ir_ready[5]), 32'd0);
      if (i == 2) ir_valid = 9'h002;
      if (i == 3) ir_valid = '0;
      tick();
    end
    check("stall_cnt", 32'(pend_cnt), 32'd2);
    check("stall_rdy1", 32'(ir_ready[1]), 32'd0);
    out_ready = 1'b1;
    tick();
    check("stall_done_ov", 32'(out_valid), 32'd0);
    tick();
    check("stall_next_ov", 32'(out_valid), 32'd1);
    check("stall_next_id", 32'(out_id), 32'd1);
    tick();
    check("stall_end_ov", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Flush while source 1 is granted with 4 and 6 also pending
    do_reset();
    ir_valid = 9'h052;
    tick();
    ir_valid = '0;
    tick();
    check("fl_ov", 32'(out_valid), 32'd1);
    check("fl_id", 32'(out_id), 32'd1);
    tick();
    check("fl_cnt3", 32'(pend_cnt), 32'd3);
    flush = 1'b1;
    ir_valid = 9'h001;
    #1;
    check("fl_rdy0", 32'(ir_ready), 32'd0);
    tick();
    flush = 1'b0;
    ir_valid = '0;
    check("fl_ov_held", 32'(out_valid), 32'd1);
    check("fl_id_held", 32'(out_id), 32'd1);
    tick();
    check("fl_cnt1", 32'(pend_cnt), 32'd1);
    check("fl_rdy", 32'(ir_ready), 32'h1FD);
    out_ready = 1'b1;
    tick();
    check("fl_done_ov", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fl_no_more_ov", 32'(out_valid), 32'd0);
    end
    check("fl_cnt0", 32'(pend_cnt), 32'd0);
    out_ready = 1'b0;

    // Reset while granted with 3 pending, then source 7 and a same-cycle re-request
    do_reset();
    ir_valid = 9'h01C;
    tick();
    ir_valid = '0;
    tick();
    check("rg_ov", 32'(out_valid), 32'd1);
    check("rg_id", 32'(out_id), 32'd2);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    #1;
    check("rg_ov0", 32'(out_valid), 32'd0);
    check("rg_cnt0", 32'(pend_cnt), 32'd0);
    check("rg_rdy", 32'(ir_ready), 32'h1FF);
    ir_valid = 9'h080;
    tick();
    ir_valid = '0;
    tick();
    check("rg7_ov", 32'(out_valid), 32'd1);
    check("rg7_id", 32'(out_id), 32'd7);
    ir_valid = 9'h080;
    #1;
    check("rr_rdy7_busy", 32'(ir_ready[7]), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rr_ov0", 32'(out_valid), 32'd0);
    check("rr_rdy7_free", 32'(ir_ready[7]), 32'd1);
    tick();
    ir_valid = '0;
    check("rr_accept", 32'(ir_ready[7]), 32'd0);
    check("rr_ov_idle", 32'(out_valid), 32'd0);
    tick();
    check("rr_ov1", 32'(out_valid), 32'd1);
    check("rr_id", 32'(out_id), 32'd7);
    out_ready = 1'b1;
    tick();

    // All sources at once with out_ready held high
    do_reset();
    out_ready = 1'b1;
    ir_valid = 9'h1FF;
    tick();
    ir_valid = '0;
    begin
      int next_id;
      int last_t;
      next_id = 0;
      last_t  = -1;
      for (int t = 0; t < 40; t++) begin
        tick();
        if (out_valid) begin
          check("all_id", 32'(out_id), 32'(next_id));
          if (next_id == 0) check("all_cnt9", 32'(pend_cnt), 32'd9);
          else              check("all_gap", 32'(t - last_t), 32'd2);
          last_t = t;
          next_id++;
        end
      end
      check("all_count", 32'(next_id), 32'd9);
      check("all_cnt_end", 32'(pend_cnt), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
